// File: rtl/asap_bus_arbiter_if.sv
// ASAP CPU external uio bus bundle: fetch/LSU request side plus pad-side bus.
// The arbiter takes the slave view; the core/pad model takes the master view.
interface asap_bus_arbiter_if;
    logic       if_req;
    logic [7:0] if_addr;
    logic       if_gnt;
    logic       if_done;
    logic       ls_req;
    logic       ls_we;
    logic [7:0] ls_addr;
    logic [7:0] ls_wdata;
    logic       ls_gnt;
    logic       ls_done;
    logic [7:0] rdata;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       bus_ale;
    logic       bus_rd;
    logic       bus_wr;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, uio_in,
        output if_gnt, if_done, ls_gnt, ls_done, rdata,
        output uio_out, uio_oe, bus_ale, bus_rd, bus_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, uio_in,
        input  if_gnt, if_done, ls_gnt, ls_done, rdata,
        input  uio_out, uio_oe, bus_ale, bus_rd, bus_wr
    );
endinterface

// File: rtl/asap_bus_arbiter.sv
// Shares the ASAP uio bus between fetch and LSU; LSU-first with a streak cap.
// Every output is a flop loaded from the next-state decode, so nothing is combinational.
module asap_bus_arbiter #(
    parameter int WAIT_CYCLES    = 1,
    parameter int MAX_LSU_STREAK = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    asap_bus_arbiter_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, DONE} state_t;

    localparam int SW = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_LSU_STREAK);
    localparam logic [3:0] WLOAD =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          own_q, own_d;
    logic          we_q, we_d;
    logic [7:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          ls_win;
    logic [7:0]    rdata_q;

    logic [7:0] out_q, out_d;
    logic [7:0] oe_q, oe_d;
    logic       ale_q, ale_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;
    logic       ig_q, ig_d;
    logic       lg_q, lg_d;
    logic       id_q, id_d;
    logic       ld_q, ld_d;
    logic       busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            own_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            streak_q <= '0;
            rdata_q  <= '0;
            out_q    <= '0;
            oe_q     <= '0;
            ale_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ig_q     <= 1'b0;
            lg_q     <= 1'b0;
            id_q     <= 1'b0;
            ld_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            own_q    <= own_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            streak_q <= streak_d;
            if (state_q == DATA && !we_q) begin
                rdata_q <= bus.uio_in;
            end
            out_q    <= out_d;
            oe_q     <= oe_d;
            ale_q    <= ale_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ig_q     <= ig_d;
            lg_q     <= lg_d;
            id_q     <= id_d;
            ld_q     <= ld_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        own_d    = own_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        streak_d = streak_q;
        ls_win   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    ls_win  = bus.ls_req &&
                              !(bus.if_req && streak_q == SMAX);
                    state_d = ADDR;
                    cnt_d   = WLOAD;
                    if (ls_win) begin
                        own_d    = 1'b1;
                        we_d     = bus.ls_we;
                        addr_d   = bus.ls_addr;
                        wdata_d  = bus.ls_wdata;
                        streak_d = bus.if_req ? streak_q + 1'b1 : '0;
                    end else begin
                        own_d    = 1'b0;
                        we_d     = 1'b0;
                        addr_d   = bus.if_addr;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            ADDR: state_d = (WAIT_CYCLES == 0) ? DATA : WAIT;
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DATA: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output flops are loaded from the state being entered.
    always_comb begin
        out_d  = '0;
        oe_d   = '0;
        ale_d  = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        id_d   = 1'b0;
        ld_d   = 1'b0;
        busy_d = (state_d != IDLE);
        ig_d   = busy_d && !own_d;
        lg_d   = busy_d && own_d;
        unique case (state_d)
            ADDR: begin
                out_d = addr_d;
                oe_d  = 8'hFF;
                ale_d = 1'b1;
            end
            WAIT, DATA: begin
                if (we_d) begin
                    out_d = wdata_d;
                    oe_d  = 8'hFF;
                    wr_d  = (state_d == DATA);
                end else begin
                    rd_d  = 1'b1;
                end
            end
            DONE: begin
                id_d = !own_d;
                ld_d = own_d;
            end
            default: ;
        endcase
    end

    assign bus.if_gnt  = ig_q;
    assign bus.if_done = id_q;
    assign bus.ls_gnt  = lg_q;
    assign bus.ls_done = ld_q;
    assign bus.rdata   = rdata_q;
    assign bus.uio_out = out_q;
    assign bus.uio_oe  = oe_q;
    assign bus.bus_ale = ale_q;
    assign bus.bus_rd  = rd_q;
    assign bus.bus_wr  = wr_q;
endmodule

// File: tb/tb_asap_bus_arbiter.sv
// Bench for asap_bus_arbiter: random requesters against a transaction-level
// model that expands each grant into its expected per-cycle bus waveform.
module tb_asap_bus_arbiter;
    localparam int W   = 1;
    localparam int MAX = 2;
    localparam int M_MANUAL = 0;
    localparam int M_HOLD   = 1;
    localparam int M_RAND   = 2;

    typedef struct packed {
        logic [7:0] oe;
        logic [7:0] out;
        logic ale, rd, wr, ig, lg, id, ld, cap;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    asap_bus_arbiter_if b ();
    asap_bus_arbiter_if b0 ();

    asap_bus_arbiter #(.WAIT_CYCLES(W), .MAX_LSU_STREAK(MAX)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b)
    );
    asap_bus_arbiter #(.WAIT_CYCLES(0), .MAX_LSU_STREAK(MAX)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
    );

    int checks = 0;
    int errors = 0;
    int mode = M_MANUAL;
    rec_t q[$];
    rec_t cur = '0;
    logic [7:0] m_rdata = '0;
    int streak = 0;
    bit order[$];

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic push_txn(input bit ls, input bit we,
                            input logic [7:0] a, input logic [7:0] d);
        rec_t base;
        rec_t r;
        base = '0;
        base.lg = ls;
        base.ig = !ls;
        r = base; r.oe = 8'hFF; r.out = a; r.ale = 1'b1;
        q.push_back(r);
        for (int i = 0; i < W; i++) begin
            r = base;
            if (we) begin r.oe = 8'hFF; r.out = d; end
            else r.rd = 1'b1;
            q.push_back(r);
        end
        r = base;
        if (we) begin r.oe = 8'hFF; r.out = d; r.wr = 1'b1; end
        else begin r.rd = 1'b1; r.cap = 1'b1; end
        q.push_back(r);
        r = base; r.id = !ls; r.ld = ls;
        q.push_back(r);
    endtask

    task automatic model_advance();
        bit ls_win;
        if (cur.cap) m_rdata = b.uio_in;
        if (q.size() == 0 && cur == '0 && (b.if_req || b.ls_req)) begin
            ls_win = b.ls_req && !(b.if_req && streak == MAX);
            order.push_back(ls_win);
            if (ls_win) begin
                streak = b.if_req ? streak + 1 : 0;
                push_txn(1'b1, b.ls_we, b.ls_addr, b.ls_wdata);
            end else begin
                streak = 0;
                push_txn(1'b0, 1'b0, b.if_addr, 8'h00);
            end
        end
        cur = (q.size() != 0) ? q.pop_front() : '0;
    endtask

    task automatic requesters();
        if (mode == M_MANUAL) begin
            if (cur.id) b.if_req = 1'b0;
            if (cur.ld) b.ls_req = 1'b0;
        end else if (mode == M_RAND) begin
            b.uio_in = 8'($urandom);
            if (cur.id) b.if_req = 1'($urandom_range(1, 0));
            else if (!b.if_req && $urandom_range(3, 0) == 0) begin
                b.if_req  = 1'b1;
                b.if_addr = 8'($urandom);
            end else if (b.if_req && $urandom_range(31, 0) == 0)
                b.if_req = 1'b0;
            if (cur.ld) b.ls_req = 1'($urandom_range(1, 0));
            else if (!b.ls_req && $urandom_range(3, 0) == 0) begin
                b.ls_req   = 1'b1;
                b.ls_we    = 1'($urandom);
                b.ls_addr  = 8'($urandom);
                b.ls_wdata = 8'($urandom);
            end else if (b.ls_req && $urandom_range(31, 0) == 0)
                b.ls_req = 1'b0;
        end
    endtask

    task automatic compare();
        chk("uio_oe", b.uio_oe, cur.oe);
        chk("uio_out", b.uio_out, cur.out);
        chk("bus_ale", 8'(b.bus_ale), 8'(cur.ale));
        chk("bus_rd", 8'(b.bus_rd), 8'(cur.rd));
        chk("bus_wr", 8'(b.bus_wr), 8'(cur.wr));
        chk("if_gnt", 8'(b.if_gnt), 8'(cur.ig));
        chk("ls_gnt", 8'(b.ls_gnt), 8'(cur.lg));
        chk("if_done", 8'(b.if_done), 8'(cur.id));
        chk("ls_done", 8'(b.ls_done), 8'(cur.ld));
        chk("rdata", b.rdata, m_rdata);
    endtask

    task automatic step();
        requesters();
        model_advance();
        @(negedge clk);
        compare();
    endtask

    bit exp_ord [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int n;
        logic [7:0] a;
        logic [7:0] d;
        bit use_ls;
        b.if_req = 0; b.if_addr = 0; b.ls_req = 0; b.ls_we = 0;
        b.ls_addr = 0; b.ls_wdata = 0; b.uio_in = 0;
        b0.if_req = 0; b0.if_addr = 0; b0.ls_req = 0; b0.ls_we = 0;
        b0.ls_addr = 0; b0.ls_wdata = 0; b0.uio_in = 0;

        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;

        // Fetch read at 0x3C returning 0xA5.
        b.uio_in = 8'hA5;
        b.if_addr = 8'h3C;
        b.if_req = 1'b1;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (b.if_done) begin n = i; break; end
        end
        chk("if_done_latency", 8'(n), 8'd4);
        repeat (3) step();
        chk("fetch_rdata", b.rdata, 8'hA5);

        // LSU write; rdata must be untouched.
        b.uio_in = 8'h11;
        b.ls_we = 1'b1; b.ls_addr = 8'h80; b.ls_wdata = 8'h5A;
        b.ls_req = 1'b1;
        repeat (7) step();
        chk("write_keeps_rdata", b.rdata, 8'hA5);

        // Both requesters held: starvation guard ordering.
        order.delete();
        mode = M_HOLD;
        b.ls_we = 1'b0; b.ls_addr = 8'h42; b.if_addr = 8'h24;
        b.uio_in = 8'h77;
        b.if_req = 1'b1; b.ls_req = 1'b1;
        repeat (30) step();
        chk("order_len", 8'(order.size() >= 6), 8'd1);
        for (int i = 0; i < 6; i++)
            if (i < order.size())
                chk($sformatf("grant_order%0d", i),
                    8'(order[i]), 8'(exp_ord[i]));
        b.if_req = 1'b0; b.ls_req = 1'b0;
        mode = M_MANUAL;
        repeat (8) step();

        // Asynchronous reset in the WAIT phase of an LSU write.
        b.ls_we = 1'b1; b.ls_addr = 8'h80; b.ls_wdata = 8'h5A;
        b.ls_req = 1'b1;
        step();
        step();
        chk("in_wait_oe", b.uio_oe, 8'hFF);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_oe", b.uio_oe, 8'h00);
        chk("rst_out", b.uio_out, 8'h00);
        chk("rst_wr", 8'(b.bus_wr), 8'd0);
        chk("rst_gnt", 8'(b.ls_gnt), 8'd0);
        chk("rst_done", 8'(b.ls_done), 8'd0);
        chk("rst_rdata", b.rdata, 8'h00);
        b.ls_req = 1'b0;
        @(negedge clk);
        chk("rst_hold_done", 8'(b.ls_done), 8'd0);
        rst_n = 1'b1;
        q.delete();
        cur = '0;
        streak = 0;
        m_rdata = 8'h00;
        b.ls_req = 1'b1;
        repeat (7) step();

        // Randomised traffic.
        mode = M_RAND;
        repeat (1500) step();
        mode = M_MANUAL;
        b.if_req = 1'b0; b.ls_req = 1'b0;
        repeat (8) step();

        // Zero-wait build: ADDR, DATA, DONE, then IDLE.
        for (int t = 0; t < 8; t++) begin
            a = 8'($urandom);
            d = 8'($urandom);
            use_ls = 1'($urandom);
            b0.uio_in = d;
            b0.ls_we = !use_ls;
            b0.if_addr = a; b0.ls_addr = a;
            if (use_ls) b0.ls_req = 1'b1;
            else b0.if_req = 1'b1;
            @(negedge clk);
            chk("w0_addr_ale", 8'(b0.bus_ale), 8'd1);
            chk("w0_addr_out", b0.uio_out, a);
            chk("w0_addr_oe", b0.uio_oe, 8'hFF);
            @(negedge clk);
            chk("w0_data_rd", 8'(b0.bus_rd), 8'd1);
            chk("w0_data_oe", b0.uio_oe, 8'h00);
            chk("w0_data_wr", 8'(b0.bus_wr), 8'd0);
            @(negedge clk);
            chk("w0_done", 8'(use_ls ? b0.ls_done : b0.if_done), 8'd1);
            chk("w0_rdata", b0.rdata, d);
            b0.if_req = 1'b0; b0.ls_req = 1'b0;
            @(negedge clk);
            chk("w0_idle_gnt", 8'(b0.if_gnt | b0.ls_gnt), 8'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/asap_bus_arbiter.md
# asap_bus_arbiter

Sequences and shares the ASAP CPU's single external 8-bit `uio` bus between the instruction-fetch unit and the load/store unit. Each granted request runs a fixed address/wait/data bus cycle, and the block drives `uio_out`/`uio_oe` plus strobes. It sits between the CPU core and the `tt_um_lbkh_asap_cpu_v1` pad ring. The LSU has priority, and a streak limit prevents fetch starvation.

## Interface
- `WAIT_CYCLES`, 1: wait-state cycles between address and data phase (0..15).
- `MAX_LSU_STREAK`, 2: consecutive LSU grants allowed while fetch is pending (>=1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `if_req` in 1: fetch read request; level, held until `if_done`.
- `if_addr` in 8: fetch address; stable while `if_req`.
- `if_gnt` out 1: fetch owns the bus (ADDR..DONE).
- `if_done` out 1: one-cycle pulse; `rdata` valid.
- `ls_req` in 1: LSU request; level, held until `ls_done`.
- `ls_we` in 1: 1 = write, 0 = read; stable while `ls_req`.
- `ls_addr` in 8: LSU address.
- `ls_wdata` in 8: LSU write data.
- `ls_gnt` out 1: LSU owns the bus.
- `ls_done` out 1: one-cycle pulse; for a read, `rdata` is valid.
- `rdata` out 8: last read byte; holds until the next read completes.
- `uio_in` in 8: bus input.
- `uio_out` out 8: bus output.
- `uio_oe` out 8: bus output enable (0xFF drive, 0x00 release).
- `bus_ale` out 1: address-latch strobe.
- `bus_rd` out 1: read strobe.
- `bus_wr` out 1: write strobe.

## Operation
- **States:** IDLE, ADDR, WAIT, DATA, DONE.
- **IDLE:** sample requests on each edge.
  - No request: stay in IDLE.
  - Any request: latch owner, address, direction and wdata, then go to ADDR.
- **Arbitration (in IDLE):**
  - `ls_req` wins unless `if_req` is pending and `streak == MAX_LSU_STREAK`.
  - `streak` increments on an LSU grant while `if_req` is high.
  - `streak` clears on any fetch grant, and on an LSU grant when `if_req` is low.
- **ADDR (1 cycle):** `uio_out` = addr, `uio_oe` = 0xFF, `bus_ale` = 1. Next state is WAIT, or DATA if `WAIT_CYCLES` = 0.
- **WAIT (`WAIT_CYCLES` cycles, down-counter):**
  - Read: `uio_oe` = 0x00, `bus_rd` = 1.
  - Write: `uio_oe` = 0xFF, `uio_out` = wdata, `bus_wr` = 0.
- **DATA (1 cycle):**
  - Read: `uio_oe` = 0x00, `bus_rd` = 1; `uio_in` is captured into `rdata` at the edge ending DATA.
  - Write: `uio_oe` = 0xFF, `uio_out` = wdata, `bus_wr` = 1.
- **DONE (1 cycle):** owner's `*_done` = 1, `uio_oe` = 0x00, all strobes 0. Next state is IDLE.
- **Grant:** the owner's `*_gnt` is high in ADDR, WAIT, DATA and DONE. Both grants are never high together.
- **Fetch direction:** fetch is always a read. `ls_we` is ignored for fetch.
- **Bus-output invariants:**
  - `bus_rd` and `bus_wr` are never high together.
  - `bus_ale` is high only in ADDR.
  - `uio_out` = 0x00 whenever `uio_oe` = 0x00.
- **Request drop:** a request withdrawn mid-transaction is ignored. The transaction completes and `done` still pulses.

## Timing
- All outputs are registered and change only on the state-transition edge. No combinational input-to-output paths.
- **Reset values:** state IDLE, `uio_out` 0x00, `uio_oe` 0x00, `bus_ale`/`bus_rd`/`bus_wr` 0, both gnt 0, both done 0, `rdata` 0x00, `streak` 0.
- **Asynchronous reset mid-transaction:** the bus is released immediately, no `done` is issued, and `rdata` is cleared.
- **Latency:** request high in IDLE at edge k gives ADDR in cycle k+1 and `done` in cycle k+3+`WAIT_CYCLES`.
- **Bus occupancy:** 3+`WAIT_CYCLES` cycles per transaction, plus at least 1 IDLE cycle between transactions.
- **Requester handshake:** the requester drops `req` at the edge where it sees `done`. IDLE therefore never re-grants a completed request.
- **Back-to-back requests:** a requester holding `req` after `done` gets a new transaction.

## Test plan
- **Fetch read, `WAIT_CYCLES`=1:**
  - Stimulus: `if_addr`=0x3C, `uio_in`=0xA5 in DATA.
  - Response: ADDR drives 0x3C with oe 0xFF and ale; WAIT has rd=1 and oe 0x00; DATA has rd=1; `if_done` pulses 4 cycles after the request edge; `rdata`=0xA5.
- **LSU write:**
  - Stimulus: `ls_addr`=0x80, `ls_wdata`=0x5A, `ls_we`=1.
  - Response: `uio_out` 0x80 then 0x5A with oe 0xFF throughout; `bus_wr` high only in DATA; `ls_done` pulses; `rdata` unchanged.
- **Simultaneous requests:**
  - Stimulus: `if_req` and `ls_req` rise on the same edge.
  - Response: `ls_gnt` first; `if_gnt` starts in the ADDR after the next IDLE.
- **Starvation guard, `MAX_LSU_STREAK`=2:**
  - Stimulus: `ls_req` held continuously, `if_req` held.
  - Response: grant order LS, LS, IF, LS, LS, IF.
- **Reset during WAIT:**
  - Stimulus: assert `rst_n` low mid-WAIT of an LSU write, then release.
  - Response: `uio_oe` goes to 0x00 and strobes to 0 without waiting for a clock; no `ls_done`; after release, IDLE and a fresh request completes normally.
- **`WAIT_CYCLES`=0 build:**
  - Stimulus: single read.
  - Response: ADDR goes directly to DATA; `done` arrives 3 cycles after the request edge; `rdata` correct.
